// File: rtl/sel_mux_pkg.sv
// Shared constants and select classification for the N-way selector pipeline.
package sel_mux_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_NUM_IN = 3;
  localparam int DEF_CNT_W  = 8;

  // Widest select vector the classifier accepts (NUM_IN-1 must not exceed it).
  localparam int MAX_SEL_W  = 32;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ONE,
    SEL_MULTI
  } sel_class_t;

  function automatic sel_class_t onehot_ok(input logic [MAX_SEL_W-1:0] sel);
    if (sel == '0) return SEL_NONE;
    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    if ((sel & (sel - 1'b1)) == '0) return SEL_ONE;
    return SEL_MULTI;
  endfunction

endpackage

// File: rtl/sel_onehot_decode.sv
// Combinational select decode: one-hot select bits to a slot index plus a none/one/multi class.
module sel_onehot_decode
  import sel_mux_pkg::*;
#(
  parameter  int NUM_IN = DEF_NUM_IN,
  localparam int IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-2:0] sel_i,
  output logic [IDX_W-1:0]  slot_idx_o,
  output sel_class_t        sel_class_o
);

  logic [MAX_SEL_W-1:0] sel_ext;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    sel_ext              = '0;
    sel_ext[NUM_IN-2:0]  = sel_i;
    slot_idx_o           = '0;
    for (int k = 1; k < NUM_IN; k++) begin
      if (sel_i[k-1]) slot_idx_o = slot_idx_o | IDX_W'(k);
    end
    sel_class_o = onehot_ok(sel_ext);
  end

endmodule

// File: rtl/sel_mux_pipe.sv
// N-way W-bit selector with a valid/ready output register and a saturating conflict counter.
module sel_mux_pipe
  import sel_mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-2:0]       sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_conflict,
  output logic [CNT_W-1:0]        conflict_cnt,
  input  logic                    cnt_clr
);

  localparam int              IDX_W   = $clog2(NUM_IN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [IDX_W-1:0] slot_idx;
  sel_class_t       sel_class;
  logic [WIDTH-1:0] mux_data;
  logic             mux_conflict;
  logic             accept;

  logic             valid_q,    valid_d;
  logic [WIDTH-1:0] data_q,     data_d;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  sel_onehot_decode #(.NUM_IN(NUM_IN)) u_decode (
    .sel_i       (sel),
    .slot_idx_o  (slot_idx),
    .sel_class_o (sel_class)
  );

  // AND-OR mux; a conflict masks every slot so the data goes to zero.
  always_comb begin
    mux_conflict = (sel_class == SEL_MULTI);
    mux_data     = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      mux_data = mux_data |
        (in_data[k*WIDTH +: WIDTH] & {WIDTH{(slot_idx == IDX_W'(k)) && !mux_conflict}});
    end
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    conflict_d = conflict_q;
    cnt_d      = cnt_q;

    if (accept) begin
      valid_d    = 1'b1;
      data_d     = mux_data;
      conflict_d = mux_conflict;
    end else if (out_ready) begin
      valid_d    = 1'b0;
    end

    // Clear wins over a coincident conflict beat; the count sticks at all-ones.
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (accept && mux_conflict && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_data     = data_q;
  assign out_conflict = conflict_q;
  assign conflict_cnt = cnt_q;

endmodule
